// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: runs 16-sclk frames on an 8-channel serial ADC and walks
// the enabled channels of a latched mask. Each 12-bit result goes out with its
// channel tag on a valid/ready stream.
// Optional build macro ADC_SCAN_AVG_EN: each channel is converted four times and
// the truncated mean of the four samples is returned.
module adc_scan_scheduler #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 12
) (
  input  logic                      sclk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [NUM_CH-1:0]         ch_mask,
  output logic                      busy,
  output logic                      cs_n,
  output logic                      dout,
  input  logic                      din,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  output logic [DATA_W-1:0]         res_data
);

  localparam int unsigned CH_W        = $clog2(NUM_CH);
  localparam int unsigned FRAME_LEN   = 16;
  localparam int unsigned CNT_W       = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] SHIFT_START = CNT_W'(FRAME_LEN - DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ADDR_CNT2   = CNT_W'(2);
  localparam logic [CNT_W-1:0] ADDR_CNT1   = CNT_W'(3);
  localparam logic [CNT_W-1:0] ADDR_CNT0   = CNT_W'(4);
`ifdef ADC_SCAN_AVG_EN
  localparam int unsigned ACC_W    = DATA_W + 2;
  localparam logic [1:0]  REP_LAST = 2'd3;
`endif

  typedef enum logic [1:0] {IDLE, FRAME, HOLD} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic                cont_q, cont_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                cs_n_q, cs_n_d;
  logic                dout_q, dout_d;
  logic                res_valid_q, res_valid_d;
  logic [CH_W-1:0]     res_ch_q, res_ch_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
`ifdef ADC_SCAN_AVG_EN
  logic [1:0]          rep_q, rep_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    acc_sum;
`endif

  logic [DATA_W-1:0]   sample;
  logic [DATA_W-1:0]   result;
  logic                deliver;
  logic                advance;
  logic [CH_W:0]       nxt;

  // Lowest enabled channel in a mask (mask is known non-zero where used).
  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // Next enabled channel strictly above cur; MSB flags that one was found.
  function automatic logic [CH_W:0] next_above(input logic [NUM_CH-1:0] m,
                                               input logic [CH_W-1:0]   cur);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ch_d        = ch_q;
    mask_d      = mask_q;
    cont_d      = cont_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    res_valid_d = res_valid_q & ~res_ready;
    res_ch_d    = res_ch_q;
    res_data_d  = res_data_q;
    sample      = {shift_q[DATA_W-2:0], din};
    result      = sample;
    deliver     = 1'b0;
    advance     = 1'b0;
    nxt         = next_above(mask_q, ch_q);
`ifdef ADC_SCAN_AVG_EN
    rep_d       = rep_q;
    acc_d       = acc_q;
    acc_sum     = ((rep_q == 2'd0) ? ACC_W'(0) : acc_q) + ACC_W'(sample);
    result      = acc_sum[ACC_W-1:2];
`endif

    unique case (state_q)
      IDLE: begin
        if (start && (ch_mask != '0)) begin
          mask_d  = ch_mask;
          cont_d  = continuous;
          ch_d    = lowest_set(ch_mask);
          count_d = '0;
          state_d = FRAME;
`ifdef ADC_SCAN_AVG_EN
          rep_d   = 2'd0;
`endif
        end
      end
      FRAME: begin
        count_d = count_q + CNT_W'(1);
        if (count_q >= SHIFT_START) shift_d = sample;
        if (count_q == LAST_CNT) begin
`ifdef ADC_SCAN_AVG_EN
          if (rep_q == REP_LAST) begin
            deliver = 1'b1;
          end else begin
            acc_d = acc_sum;
            rep_d = rep_q + 2'd1;
          end
`else
          deliver = 1'b1;
`endif
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b1;
          res_ch_d    = ch_q;
          res_data_d  = hold_q;
          advance     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Hand a finished result to the output register, or park it if still occupied.
    if (deliver) begin
      if (!res_valid_q || res_ready) begin
        res_valid_d = 1'b1;
        res_ch_d    = ch_q;
        res_data_d  = result;
        advance     = 1'b1;
      end else begin
        hold_d  = result;
        state_d = HOLD;
      end
    end

    // Pick the next channel, restart the pass, or stop.
    if (advance) begin
      count_d = '0;
`ifdef ADC_SCAN_AVG_EN
      rep_d   = 2'd0;
`endif
      if (nxt[CH_W]) begin
        ch_d    = nxt[CH_W-1:0];
        state_d = FRAME;
      end else if (cont_q && continuous) begin
        ch_d    = lowest_set(mask_q);
        state_d = FRAME;
      end else begin
        cont_d  = 1'b0;
        state_d = IDLE;
      end
    end

    cs_n_d = (state_d != FRAME);
    busy_d = (state_d != IDLE);
    dout_d = 1'b0;
    if (state_d == FRAME) begin
      case (count_d)
        ADDR_CNT2: dout_d = ch_d[2];
        ADDR_CNT1: dout_d = ch_d[1];
        ADDR_CNT0: dout_d = ch_d[0];
        default:   dout_d = 1'b0;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      ch_q        <= '0;
      mask_q      <= '0;
      cont_q      <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      dout_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_data_q  <= '0;
`ifdef ADC_SCAN_AVG_EN
      rep_q       <= 2'd0;
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ch_q        <= ch_d;
      mask_q      <= mask_d;
      cont_q      <= cont_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      cs_n_q      <= cs_n_d;
      dout_q      <= dout_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_data_q  <= res_data_d;
`ifdef ADC_SCAN_AVG_EN
      rep_q       <= rep_d;
      acc_q       <= acc_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign cs_n      = cs_n_q;
  assign dout      = dout_q;
  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with a behavioural ADC that decodes the
// channel address from dout and returns 0x100+ch (or a fixed 4-sample sequence
// when ADC_SCAN_AVG_EN is defined).
module tb_adc_scan_scheduler;

  logic        sclk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        din = 1'b0;
  logic        res_ready = 1'b0;
  logic        busy;
  logic        cs_n;
  logic        dout;
  logic        res_valid;
  logic [2:0]  res_ch;
  logic [11:0] res_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sclk = ~sclk;

  adc_scan_scheduler dut (
    .sclk       (sclk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .ch_mask    (ch_mask),
    .busy       (busy),
    .cs_n       (cs_n),
    .dout       (dout),
    .din        (din),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_ch     (res_ch),
    .res_data   (res_data)
  );

  // ADC model: counts frame cycles while cs_n is low, captures the address,
  // and presents sample bits MSB first for the rising edges at counts 4..15.
  logic [3:0]  mcnt = 4'd0;
  logic [2:0]  mch  = 3'd0;
  logic [11:0] mval = 12'd0;
`ifdef ADC_SCAN_AVG_EN
  logic [11:0] avg_tab [4] = '{12'h100, 12'h101, 12'h102, 12'h104};
  int unsigned mframe = 0;
`endif

  always @(negedge sclk) begin
    if (rst || cs_n) begin
      mcnt = 4'd0;
      din  = 1'b0;
    end else begin
      case (mcnt)
        4'd2: mch[2] = dout;
        4'd3: mch[1] = dout;
        4'd4: mch[0] = dout;
        default: ;
      endcase
`ifdef ADC_SCAN_AVG_EN
      mval = avg_tab[mframe & 3];
`else
      mval = 12'h100 + 12'(mch);
`endif
      if (mcnt >= 4'd4) din = mval[4'd15 - mcnt];
`ifdef ADC_SCAN_AVG_EN
      if (mcnt == 4'd15) mframe++;
`endif
      mcnt = mcnt + 4'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Pulse start for one cycle; returns one step after the edge that samples it.
  task automatic do_start(input logic [7:0] mask, input logic cont);
    ch_mask    = mask;
    continuous = cont;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    ticks(3);
    check("rst_cs_n",      32'(cs_n),      32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_valid",     32'(res_valid), 32'd0);
    check("rst_ch",        32'(res_ch),    32'd0);
    check("rst_data",      32'(res_data),  32'd0);
    check("rst_dout",      32'(dout),      32'd0);
    rst = 1'b0;
    tick();

`ifdef ADC_SCAN_AVG_EN
    res_ready = 1'b1;
    do_start(8'h01, 1'b0);
    check("avg_cs_n_low",  32'(cs_n),      32'd0);
    check("avg_busy",      32'(busy),      32'd1);
    ticks(16);
    check("avg_no_res16",  32'(res_valid), 32'd0);
    ticks(16);
    check("avg_no_res32",  32'(res_valid), 32'd0);
    ticks(31);
    check("avg_no_res63",  32'(res_valid), 32'd0);
    tick();
    check("avg_valid",     32'(res_valid), 32'd1);
    check("avg_ch",        32'(res_ch),    32'd0);
    check("avg_data",      32'(res_data),  32'h101);
    check("avg_idle",      32'(busy),      32'd0);
`else
    // One-shot over channels 0, 2, 7 with no backpressure.
    res_ready = 1'b1;
    do_start(8'b1000_0101, 1'b0);
    check("os_cs_n_low",   32'(cs_n),      32'd0);
    check("os_busy",       32'(busy),      32'd1);
    ticks(15);
    check("os_no_res_yet", 32'(res_valid), 32'd0);
    tick();
    check("os_r0_valid",   32'(res_valid), 32'd1);
    check("os_r0_ch",      32'(res_ch),    32'd0);
    check("os_r0_data",    32'(res_data),  32'h100);
    ticks(16);
    check("os_r1_valid",   32'(res_valid), 32'd1);
    check("os_r1_ch",      32'(res_ch),    32'd2);
    check("os_r1_data",    32'(res_data),  32'h102);
    ticks(15);
    check("os_busy_last",  32'(busy),      32'd1);
    tick();
    check("os_r2_valid",   32'(res_valid), 32'd1);
    check("os_r2_ch",      32'(res_ch),    32'd7);
    check("os_r2_data",    32'(res_data),  32'h107);
    check("os_end_busy",   32'(busy),      32'd0);
    check("os_end_cs_n",   32'(cs_n),      32'd1);
    tick();
    check("os_drained",    32'(res_valid), 32'd0);

    // Address pattern for channel 5: 1,0,1 at counts 2,3,4.
    do_start(8'h20, 1'b0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("dout_cnt%0d", k), 32'(dout), ((k == 2) || (k == 4)) ? 32'd1 : 32'd0);
      tick();
    end
    check("dout_res_ch",   32'(res_ch),    32'd5);
    check("dout_res_data", 32'(res_data),  32'h105);
    tick();

    // Backpressure: ch0 result parked, ch1 sample held in HOLD, then both delivered.
    res_ready = 1'b0;
    do_start(8'h03, 1'b0);
    ticks(16);
    check("bp_r0_valid",   32'(res_valid), 32'd1);
    check("bp_r0_data",    32'(res_data),  32'h100);
    tick();
    check("bp_frame1_cs",  32'(cs_n),      32'd0);
    ticks(16);
    check("bp_hold_cs_n",  32'(cs_n),      32'd1);
    check("bp_hold_busy",  32'(busy),      32'd1);
    check("bp_hold_ch",    32'(res_ch),    32'd0);
    ticks(7);
    check("bp_stable_dat", 32'(res_data),  32'h100);
    check("bp_stable_vld", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    tick();
    check("bp_r1_valid",   32'(res_valid), 32'd1);
    check("bp_r1_ch",      32'(res_ch),    32'd1);
    check("bp_r1_data",    32'(res_data),  32'h101);
    check("bp_r1_idle",    32'(busy),      32'd0);
    tick();
    check("bp_drained",    32'(res_valid), 32'd0);

    // Continuous on channel 4, then drop continuous mid-pass.
    do_start(8'h10, 1'b1);
    ticks(16);
    check("cont_r0_ch",    32'(res_ch),    32'd4);
    check("cont_r0_data",  32'(res_data),  32'h104);
    check("cont_r0_cs",    32'(cs_n),      32'd0);
    ticks(16);
    check("cont_r1_valid", 32'(res_valid), 32'd1);
    check("cont_r1_busy",  32'(busy),      32'd1);
    ticks(8);
    continuous = 1'b0;
    ticks(8);
    check("cont_r2_valid", 32'(res_valid), 32'd1);
    check("cont_r2_data",  32'(res_data),  32'h104);
    check("cont_end_busy", 32'(busy),      32'd0);
    check("cont_end_cs",   32'(cs_n),      32'd1);
    tick();

    // Synchronous reset at count 9 of the second frame, with a result pending.
    res_ready = 1'b0;
    do_start(8'h03, 1'b0);
    ticks(25);
    check("rm_pre_valid",  32'(res_valid), 32'd1);
    check("rm_pre_cs",     32'(cs_n),      32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_cs_n",       32'(cs_n),      32'd1);
    check("rm_valid",      32'(res_valid), 32'd0);
    check("rm_busy",       32'(busy),      32'd0);
    check("rm_data",       32'(res_data),  32'd0);
    do_start(8'h00, 1'b0);
    check("zm_busy",       32'(busy),      32'd0);
    check("zm_cs_n",       32'(cs_n),      32'd1);
    ticks(20);
    check("zm_valid",      32'(res_valid), 32'd0);
    check("zm_busy_late",  32'(busy),      32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
Sequences the 8-channel serial ADC chip: runs 16-sclk conversion frames, walks the enabled channels in a latched mask, and returns each 12-bit result with its channel tag over a valid/ready stream.
Sits between the ADC pins and any consumer that needs flow control, e.g. a DMA writer or a filter pipeline.
Supports one-shot scans and continuous scans.

Parameters:
NUM_CH, 8, number of ADC channels; channel address width is log2(NUM_CH) = 3
DATA_W, 12, ADC sample width
FRAME_LEN, 16, sclk cycles per conversion frame (fixed protocol; not for override)

Ports:
sclk  in  1  system clock; also the ADC serial clock
rst  in  1  synchronous reset, active-high
start  in  1  pulse; begins a scan when idle
continuous  in  1  1 = repeat passes; sampled at start and at each end of pass
ch_mask  in  8  channel enable mask; latched at start
busy  out  1  high from the first frame through the end of the final frame or hold
cs_n  out  1  ADC chip select, active-low
dout  out  1  serial channel address to the ADC
din  in  1  serial sample from the ADC, MSB first
res_valid  out  1  result available
res_ready  in  1  consumer accepts the result
res_ch  out  3  channel of the result
res_data  out  12  sample value

Behaviour:
- Reset values (sync rst, overrides everything):
  - state = IDLE; frame count = 0.
  - cs_n = 1, dout = 0, busy = 0, res_valid = 0, res_ch = 0, res_data = 0.
  - A pending or in-flight sample is discarded.
- States: IDLE, FRAME, HOLD.
- IDLE:
  - start = 1 with ch_mask != 0: latch mask and continuous; channel = lowest set mask bit; go to FRAME with count = 0.
  - cs_n falls on the first cycle after start; busy = 1 from that cycle.
  - start with ch_mask = 0 is ignored; start while busy is ignored.
- FRAME:
  - cs_n = 0; count increments 0..15 and wraps to 0.
  - dout = ch[2] at count 2, ch[1] at count 3, ch[0] at count 4; 0 otherwise.
  - din is shifted into a 12-bit register (MSB first) on rising sclk at counts 4..15.
- End of frame (edge at count 15), sample = {shift[10:0], din}:
  - If !res_valid or res_ready: result register loads sample and channel; res_valid = 1 next cycle.
  - Otherwise go to HOLD with the sample held.
- Next channel:
  - The next set mask bit above the current channel, ascending.
  - Wrap past bit 7 = end of pass.
  - End of pass with latched continuous = 0 → IDLE, cs_n = 1, busy = 0.
  - End of pass with continuous = 1 → re-sample the continuous input: 1 = restart at the lowest set bit; 0 = IDLE.
  - Otherwise the next frame follows back-to-back (count 0 on the next cycle, cs_n stays low).
- HOLD:
  - cs_n = 1, dout = 0, busy = 1.
  - On res_valid && res_ready, the held sample loads into the result register (res_valid stays 1).
  - Then continue as at end of frame: next frame or IDLE.
  - Samples are never dropped or overwritten.
- Output handshake: res_ch and res_data are stable while res_valid && !res_ready. A result is consumed on the cycle where res_valid && res_ready.
- Latency: first result valid 17 cycles after the start cycle. Throughput: one result per 16 cycles when there is no backpressure.
- Single enabled channel: repeated frames on that channel; a pass is one frame long.
- Mask changes while busy have no effect until the next start.

Optional Feature:
ADC_SCAN_AVG_EN
- Defined:
  - Each channel is converted in 4 consecutive frames.
  - Samples are summed in a 14-bit accumulator, cleared at the first frame of each channel.
  - res_data = sum[13:2] (truncating mean); one result per channel per 4 frames.
  - Backpressure/HOLD applies only to the 4th frame's result.
  - First result valid 65 cycles after start.
- Undefined: one frame per channel, as above; no accumulator logic is present.

Test Plan:
- One-shot, ch_mask=8'b1000_0101, model returns 12'h100+ch, res_ready=1 → results (0,0x100), (2,0x102), (7,0x107); first at start+17, then every 16 cycles; busy/cs_n deassert after the third frame.
- dout check: channel 5 → dout pattern 1,0,1 at counts 2,3,4 of that frame, 0 elsewhere.
- Backpressure: ch_mask=8'h03, res_ready=0 for 40 cycles → ch0 result held stable; HOLD after the ch1 frame with cs_n=1; release → ch0 then ch1 delivered in order with no loss.
- Continuous, ch_mask=8'h10 → ch4 results every 16 cycles; drop continuous → the current frame completes, then IDLE.
- Sync rst mid-frame at count 9 → next cycle cs_n=1, res_valid=0, busy=0; a subsequent start with ch_mask=0 → stays IDLE.
- With ADC_SCAN_AVG_EN, model returns 0x100, 0x101, 0x102, 0x104 → single result 0x101 at start+65.
